// File: rtl/rx_frame_ctrl.sv
// +----------------------------------------------------------------------------+
// | rx_frame_ctrl: OFDM RX sequencer (preamble skip, CP strip, FFT framing)   |
// | Optional watchdog: define RX_FRAME_CTRL_TIMEOUT_EN   Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module rx_frame_ctrl #(
  parameter int PRE_LEN   = 160,
  parameter int CP_LEN    = 16,
  parameter int FFT_LEN   = 64,
  parameter int GUARD_LEN = 32
`ifdef RX_FRAME_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       det_frame_en,
  input  logic       in_vld,
  input  logic [7:0] in_r,
  input  logic [7:0] in_i,
  input  logic [7:0] cfg_sym_num,
  output logic       fft_vld,
  output logic [7:0] fft_r,
  output logic [7:0] fft_i,
  output logic       fft_start,
  output logic       fft_last,
  output logic [7:0] sym_idx,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       err_overrun,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SKIP_PRE = 3'd1,
    S_CP       = 3'd2,
    S_DATA     = 3'd3,
    S_GUARD    = 3'd4
  } state_t;

  localparam logic [7:0] C_PRE_LAST   = 8'(PRE_LEN - 1);
  localparam logic [7:0] C_CP_LAST    = 8'(CP_LEN - 1);
  localparam logic [7:0] C_FFT_LAST   = 8'(FFT_LEN - 1);
  localparam logic [7:0] C_GUARD_LAST = 8'(GUARD_LEN - 1);

  state_t     state_q;
  logic       prev_q;
  logic [7:0] samp_cnt_q;
  logic [7:0] sym_tot_q;
  logic [7:0] sym_idx_q;
  logic       busy_q;
  logic       fft_vld_q;
  logic [7:0] fft_r_q;
  logic [7:0] fft_i_q;
  logic       fft_start_q;
  logic       fft_last_q;
  logic       done_q;
  logic       overrun_q;
  logic       w_rise;

  assign w_rise = det_frame_en & ~prev_q;

`ifdef RX_FRAME_CTRL_TIMEOUT_EN
  localparam int C_WD_W = $clog2(TIMEOUT + 1);
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);
  logic              timeout_q;
  logic [C_WD_W-1:0] wd_q;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      prev_q      <= 1'b0;
      samp_cnt_q  <= 8'd0;
      sym_tot_q   <= 8'd0;
      sym_idx_q   <= 8'd0;
      busy_q      <= 1'b0;
      fft_vld_q   <= 1'b0;
      fft_r_q     <= 8'd0;
      fft_i_q     <= 8'd0;
      fft_start_q <= 1'b0;
      fft_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_FRAME_CTRL_TIMEOUT_EN
      timeout_q   <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      prev_q      <= det_frame_en;
      fft_vld_q   <= 1'b0;
      fft_start_q <= 1'b0;
      fft_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= w_rise && (state_q != S_IDLE);

      case (state_q)
        S_IDLE: begin
          if (w_rise) begin
            sym_tot_q  <= cfg_sym_num;
            sym_idx_q  <= 8'd0;
            busy_q     <= 1'b1;
            state_q    <= S_SKIP_PRE;
            // A sample coincident with the edge is preamble sample 0.
            samp_cnt_q <= in_vld ? 8'd1 : 8'd0;
          end
        end

        S_SKIP_PRE: begin
          if (in_vld) begin
            if (samp_cnt_q == C_PRE_LAST) begin
              samp_cnt_q <= 8'd0;
              if (sym_tot_q == 8'd0) begin
                done_q  <= 1'b1;
                state_q <= S_GUARD;
              end else begin
                state_q <= S_CP;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 8'd1;
            end
          end
        end

        S_CP: begin
          if (in_vld) begin
            if (samp_cnt_q == C_CP_LAST) begin
              samp_cnt_q <= 8'd0;
              state_q    <= S_DATA;
            end else begin
              samp_cnt_q <= samp_cnt_q + 8'd1;
            end
          end
        end

        S_DATA: begin
          if (in_vld) begin
            fft_vld_q   <= 1'b1;
            fft_r_q     <= in_r;
            fft_i_q     <= in_i;
            fft_start_q <= (samp_cnt_q == 8'd0);
            fft_last_q  <= (samp_cnt_q == C_FFT_LAST);
            if (samp_cnt_q == C_FFT_LAST) begin
              samp_cnt_q <= 8'd0;
              if (sym_idx_q == sym_tot_q - 8'd1) begin
                done_q  <= 1'b1;
                state_q <= S_GUARD;
              end else begin
                sym_idx_q <= sym_idx_q + 8'd1;
                state_q   <= S_CP;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 8'd1;
            end
          end
        end

        S_GUARD: begin
          // Hold-off counts clock cycles, not samples.
          if (samp_cnt_q == C_GUARD_LAST) begin
            samp_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            samp_cnt_q <= samp_cnt_q + 8'd1;
          end
        end

        default: begin
          samp_cnt_q <= 8'd0;
          state_q    <= S_IDLE;
        end
      endcase

`ifdef RX_FRAME_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
      if ((state_q == S_SKIP_PRE) || (state_q == S_CP) || (state_q == S_DATA)) begin
        if (in_vld) begin
          wd_q <= '0;
        end else if (wd_q == C_WD_LAST) begin
          // Abort overrides the sequencing above; no frame_done on this path.
          wd_q       <= '0;
          timeout_q  <= 1'b1;
          fft_vld_q  <= 1'b0;
          done_q     <= 1'b0;
          samp_cnt_q <= 8'd0;
          state_q    <= S_GUARD;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

  assign fft_vld     = fft_vld_q;
  assign fft_r       = fft_r_q;
  assign fft_i       = fft_i_q;
  assign fft_start   = fft_start_q;
  assign fft_last    = fft_last_q;
  assign sym_idx     = sym_idx_q;
  assign frame_busy  = busy_q;
  assign frame_done  = done_q;
  assign err_overrun = overrun_q;

`ifdef RX_FRAME_CTRL_TIMEOUT_EN
  assign err_timeout = timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_rx_frame_ctrl: self-checking bench for rx_frame_ctrl                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rx_frame_ctrl;

  localparam int PRE   = 160;
  localparam int CP    = 16;
  localparam int FFT   = 64;
  localparam int GUARD = 32;
  localparam int SYM   = CP + FFT;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       det_frame_en = 1'b0;
  logic       in_vld = 1'b0;
  logic [7:0] in_r = 8'd0;
  logic [7:0] in_i = 8'd0;
  logic [7:0] cfg_sym_num = 8'd0;
  logic       fft_vld, fft_start, fft_last, frame_busy, frame_done, err_overrun, err_timeout;
  logic [7:0] fft_r, fft_i, sym_idx;

  rx_frame_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .det_frame_en(det_frame_en), .in_vld(in_vld),
    .in_r(in_r), .in_i(in_i), .cfg_sym_num(cfg_sym_num),
    .fft_vld(fft_vld), .fft_r(fft_r), .fft_i(fft_i), .fft_start(fft_start),
    .fft_last(fft_last), .sym_idx(sym_idx), .frame_busy(frame_busy),
    .frame_done(frame_done), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame position derived from the count of valid samples since the edge.
  logic       m_prev, m_busy;
  int         m_k, m_tot, m_guard;
  logic       e_vld, e_start, e_last, e_done, e_over;
  logic [7:0] e_r, e_i, e_sym;

  int t_start0, t_start1, t_done, t_idle, n_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_busy = 0; m_k = 0; m_tot = 0; m_guard = 0;
    e_vld = 0; e_start = 0; e_last = 0; e_done = 0; e_over = 0;
    e_r = 0; e_i = 0; e_sym = 0;
  endtask

  task automatic consume(input logic [7:0] r, input logic [7:0] im);
    int k, j, s, o;
    k = m_k;
    m_k++;
    if (k == PRE - 1 && m_tot == 0) begin
      e_done = 1; m_guard = GUARD;
    end else if (k >= PRE) begin
      j = k - PRE; s = j / SYM; o = j % SYM;
      if (o >= CP) begin
        e_vld = 1; e_r = r; e_i = im;
        e_start = (o == CP);
        e_last  = (o == SYM - 1);
        if (e_last) begin
          if (s == m_tot - 1) begin
            e_done = 1; m_guard = GUARD;
          end else begin
            e_sym = 8'(s + 1);
          end
        end
      end
    end
  endtask

  task automatic step(input logic det, input logic vld, input logic [7:0] r, input logic [7:0] im);
    logic rise;
    @(negedge Clk);
    det_frame_en = det; in_vld = vld; in_r = r; in_i = im;
    rise = det && !m_prev;
    m_prev = det;
    e_vld = 0; e_start = 0; e_last = 0; e_done = 0; e_over = 0;
    if (!m_busy) begin
      if (rise) begin
        m_busy = 1; m_guard = 0; m_k = 0; m_tot = int'(cfg_sym_num); e_sym = 0;
        if (vld) consume(r, im);
      end
    end else begin
      if (rise) e_over = 1;
      if (m_guard > 0) begin
        m_guard--;
        if (m_guard == 0) m_busy = 0;
      end else if (vld) begin
        consume(r, im);
      end
    end
    @(posedge Clk);
    #1;
    chk("fft_vld", fft_vld, e_vld);
    if (e_vld) begin
      chk("fft_start", fft_start, e_start);
      chk("fft_last", fft_last, e_last);
    end
    chk("fft_r", fft_r, e_r);
    chk("fft_i", fft_i, e_i);
    chk("sym_idx", sym_idx, e_sym);
    chk("frame_busy", frame_busy, m_busy);
    chk("frame_done", frame_done, e_done);
    chk("err_overrun", err_overrun, e_over);
    chk("err_timeout", err_timeout, 1'b0);
  endtask

  // mode 0: continuous ramp, det held high; 1: vld toggles, ramp on valid index;
  // 2: random vld/data; 3: continuous random data with a second edge at ovr_at
  task automatic run_frame(input logic [7:0] cfg, input int mode, input int limit, input int ovr_at);
    int nstart, kv;
    logic det, vld;
    logic [7:0] r, im;
    cfg_sym_num = cfg;
    t_start0 = -1; t_start1 = -1; t_done = -1; t_idle = -1; n_ovr = 0;
    nstart = 0; kv = 0;
    for (int n = 0; n < limit; n++) begin
      case (mode)
        0: det = 1'b1;
        3: det = (n == 0) || (n >= ovr_at && n < ovr_at + 3);
        default: det = (n < 4);
      endcase
      case (mode)
        1: vld = (n % 2 == 0);
        2: vld = ($urandom_range(0, 3) != 0);
        default: vld = 1'b1;
      endcase
      if (mode <= 1) begin
        r = 8'(kv); im = ~8'(kv);
      end else begin
        r = 8'($urandom); im = 8'($urandom);
      end
      if (vld) kv++;
      step(det, vld, r, im);
      if (fft_vld && fft_start) begin
        if (nstart == 0) t_start0 = n;
        else if (nstart == 1) t_start1 = n;
        nstart++;
      end
      if (frame_done && t_done < 0) t_done = n;
      if (err_overrun) n_ovr++;
      if (n > 0 && !frame_busy) begin
        t_idle = n;
        break;
      end
    end
    chk("frame_end_bound", frame_busy, 1'b0);
    if (mode == 0) begin
      for (int n = 0; n < 100; n++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    end
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", frame_busy, 1'b0);
    chk("reset_vld", fft_vld, 1'b0);
    chk("reset_sym", sym_idx, 8'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Nominal: two symbols
    run_frame(8'd2, 0, 1000, 0);
    chk("nom_start0", t_start0, 176);
    chk("nom_start1", t_start1, 256);
    chk("nom_done", t_done, 319);
    chk("nom_idle", t_idle, 319 + GUARD);

    // Gapped input, one symbol
    run_frame(8'd1, 1, 1000, 0);
    chk("gap_start0", t_start0, 2 * 176);
    chk("gap_done", t_done, 2 * 239);
    chk("gap_idle", t_idle, 2 * 239 + GUARD);

    // Zero symbols
    run_frame(8'd0, 0, 1000, 0);
    chk("zero_start", t_start0, -1);
    chk("zero_done", t_done, PRE - 1);
    chk("zero_idle", t_idle, PRE - 1 + GUARD);

    // Overrun during DATA of symbol 0
    run_frame(8'd2, 3, 1000, 200);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_done", t_done, 319);

    // Random frames
    for (int f = 0; f < 4; f++) run_frame(8'($urandom_range(0, 4)), 2, 3000, 0);

    // Maximum symbol count
    run_frame(8'd255, 0, 21000, 0);
    chk("max_done", t_done, PRE + 255 * SYM - 1);

    // Reset in DATA at sample 30
    cfg_sym_num = 8'd2;
    for (int n = 0; n < PRE + CP + 30; n++) step(n == 0, 1'b1, 8'($urandom), 8'($urandom));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rst_vld", fft_vld, 1'b0);
    chk("rst_r", fft_r, 8'd0);
    chk("rst_busy", frame_busy, 1'b0);
    chk("rst_sym", sym_idx, 8'd0);
    chk("rst_start", fft_start, 1'b0);
    det_frame_en = 1'b0; in_vld = 1'b0;
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    run_frame(8'd1, 2, 3000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Sequences the OFDM RX datapath after frame detection.
- On a detected frame start, it skips the training preamble. Then, for each OFDM symbol, it strips the cyclic prefix and forwards exactly FFT_LEN samples to the FFT, framed with start/last markers.
- Tracks the symbol count per frame, raises done/error status, and enforces a guard hold-off before re-arming.
- Sits between Frame_Detection (FrameEnable, bitOutR/bitOutI) and the RX FFT input.

Parameters:
- PRE_LEN, 160, samples skipped after detection (short + long training).
- CP_LEN, 16, cyclic-prefix samples dropped per symbol.
- FFT_LEN, 64, data samples forwarded per symbol.
- GUARD_LEN, 32, idle cycles after frame end before re-arming.
- TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- det_frame_en  in  1  FrameEnable from frame detector; a rising edge marks frame start
- in_vld  in  1  sample strobe for in_r/in_i
- in_r  in  8  real sample
- in_i  in  8  imaginary sample
- cfg_sym_num  in  8  data symbols per frame; sampled on frame start
- fft_vld  out  1  forwarded sample valid
- fft_r  out  8  forwarded real sample
- fft_i  out  8  forwarded imaginary sample
- fft_start  out  1  first sample of a symbol (qualified by fft_vld)
- fft_last  out  1  FFT_LEN-th sample of a symbol (qualified by fft_vld)
- sym_idx  out  8  index of the current symbol, 0-based
- frame_busy  out  1  high from frame start until GUARD completes
- frame_done  out  1  one-cycle pulse when the last symbol's fft_last is issued
- err_overrun  out  1  one-cycle pulse: det_frame_en rising edge while busy
- err_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset: the asynchronous active-low reset (Rst_n = 0) clears all outputs and counters to 0 and puts the FSM in IDLE.
- All outputs are registered. A forwarded sample appears on fft_* exactly 1 cycle after the in_vld cycle that carried it.
- Edge detection: a registered copy of det_frame_en is kept. rise = det_frame_en & ~prev.
- Sample counter: samp_cnt, 8 bits. It advances only on in_vld and is cleared on every state change. When in_vld = 0, all counters hold and fft_vld = 0.
- FSM states:
  - IDLE: on rise, latch cfg_sym_num into sym_tot, set sym_idx = 0, assert frame_busy, go to SKIP_PRE. Samples arriving in the same cycle as rise count as preamble sample 0.
  - SKIP_PRE: count PRE_LEN valid samples; nothing is forwarded. On the PRE_LEN-th sample, go to CP, or to GUARD if sym_tot == 0 (frame_done pulses in that case).
  - CP: drop CP_LEN valid samples, then go to DATA.
  - DATA: forward each valid sample.
    - fft_start accompanies samp_cnt == 0; fft_last accompanies samp_cnt == FFT_LEN-1.
    - After the last sample: if sym_idx == sym_tot-1, pulse frame_done with fft_last and go to GUARD. Otherwise increment sym_idx and go to CP.
  - GUARD: count GUARD_LEN clock cycles, independent of in_vld. Then deassert frame_busy and go to IDLE.
- sym_idx holds its final value until the next frame start.
- A rise in any state other than IDLE is ignored for sequencing and pulses err_overrun for 1 cycle.
- A rise on the same cycle GUARD completes is also an overrun; the block returns to IDLE and waits for a fresh edge.
- Level-high det_frame_en without an edge never starts a frame.
- fft_r/fft_i hold their last forwarded value while fft_vld = 0.
- sym_tot = 255 is legal. The 8-bit sym_idx reaches 254 with no wrap.

Optional Feature:
- Macro: RX_FRAME_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts consecutive cycles with in_vld = 0 while in SKIP_PRE, CP or DATA.
  - It resets on any in_vld.
  - On reaching TIMEOUT: pulse err_timeout, force fft_vld = 0, skip frame_done, and go to GUARD.
- Without the macro: err_timeout is tied to 0 and no watchdog logic is built.

Test Plan:
1. Reset mid-frame: assert Rst_n = 0 while in DATA at sample 30 -> all outputs 0 immediately, FSM in IDLE. After release, no forwarding until a new rise.
2. Nominal frame: cfg_sym_num = 2, continuous in_vld, ramp data, rise at t0 ->
   - first fft_start at sample index 176 (PRE_LEN + CP_LEN) plus 1 cycle latency;
   - 64 samples per symbol;
   - second fft_start at index 256 (176 + 64 + CP_LEN);
   - frame_done with fft_last at index 319;
   - frame_busy falls 32 cycles later.
3. Gapped input: in_vld toggled 1/0 every cycle, cfg_sym_num = 1 -> identical forwarded sample sequence to scenario 2 symbol 0, with fft_vld gaps matching the input gaps.
4. Zero symbols: cfg_sym_num = 0 -> no fft_vld; frame_done on the 160th preamble sample; GUARD follows.
5. Overrun: second rise during DATA of symbol 0 -> err_overrun pulses exactly 1 cycle; the frame completes normally with sym_tot unchanged.
6. Timeout (macro defined, TIMEOUT = 1024): in_vld stopped during CP -> err_timeout pulses after 1024 idle cycles, frame_done never asserts, IDLE is reached after GUARD_LEN.
